uart_report_transmitter: RTL and testbench

Buffered 8N1 UART transmitter: the transmit-direction counterpart of the terminal's UART receive path. The VT100 parser queues reply bytes into it, such as device status reports (`ESC[5n` → `ESC[0n`) and cursor position reports (`ESC[<row>;<col>R`). It serialises them onto the host-bound TxD line at the same baud rate as the receive path. A small FIFO decouples bursty parser writes from the slow serial line.

---
 rtl/uart_report_transmitter.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_report_transmitter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_report_transmitter.sv
// Buffered 8N1 UART transmitter for terminal replies: a byte FIFO written by the
// parser feeds a start/data/stop serialiser whose TxD output is a flop.
`ifndef BAUD_RATE
`define BAUD_RATE 115200
`endif

module uart_report_transmitter #(
  parameter int ClkFrequency = 100_000_000,
  parameter int Baud         = `BAUD_RATE,
  parameter int FifoDepth    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dataValid,
  input  logic [7:0]                     data,
  output logic                           ready,
  output logic                           TxD,
  output logic                           busy,
  output logic [$clog2(FifoDepth+1)-1:0] fifoCount
);

  localparam int Divisor = (ClkFrequency + Baud / 2) / Baud;
  localparam int CntW    = (Divisor < 2) ? 1 : $clog2(Divisor);
  localparam int PtrW    = $clog2(FifoDepth);
  localparam int CountW  = $clog2(FifoDepth + 1);

  localparam logic [CntW-1:0]   CntMax    = CntW'(Divisor - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FifoDepth);

  generate
    if (Divisor < 2) begin : gBadDivisor
      $error("uart_report_transmitter: baud divisor must be at least 2");
    end
    if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : gBadDepth
      $error("uart_report_transmitter: FifoDepth must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            stateNext_s;
  logic [7:0]        fifoMem_r [FifoDepth];
  logic [PtrW-1:0]   wrPtr_r;
  logic [PtrW-1:0]   rdPtr_r;
  logic [CountW-1:0] count_r;
  logic [CountW-1:0] countNext_s;
  logic [CntW-1:0]   baudCnt_r;
  logic [CntW-1:0]   baudCntNext_s;
  logic [2:0]        bitIdx_r;
  logic [2:0]        bitIdxNext_s;
  logic [7:0]        shift_r;
  logic [7:0]        shiftNext_s;
  logic              txd_r;
  logic              txdNext_s;
  logic              busy_r;
  logic              busyNext_s;
  logic              push_s;
  logic              pop_s;
  logic              baudWrap_s;
  logic              fifoEmpty_s;
  logic              fifoFull_s;

  assign fifoEmpty_s = (count_r == CountW'(0));
  assign fifoFull_s  = (count_r == CountFull);
  assign push_s      = dataValid && !fifoFull_s;
  assign baudWrap_s  = (baudCnt_r == CntMax);

  assign ready     = !fifoFull_s;
  assign TxD       = txd_r;
  assign busy      = busy_r;
  assign fifoCount = count_r;

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic, including when the head byte is popped into the shifter.
  always_comb begin
    stateNext_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifoEmpty_s) begin
          pop_s       = 1'b1;
          stateNext_s = START;
        end else begin
          stateNext_s = IDLE;
        end
      end
      START: begin
        if (baudWrap_s) begin
          stateNext_s = DATA;
        end else begin
          stateNext_s = START;
        end
      end
      DATA: begin
        if (baudWrap_s && (bitIdx_r == 3'd7)) begin
          stateNext_s = STOP;
        end else begin
          stateNext_s = DATA;
        end
      end
      STOP: begin
        if (baudWrap_s) begin
          // A waiting byte starts immediately so frames run back to back.
          if (!fifoEmpty_s) begin
            pop_s       = 1'b1;
            stateNext_s = START;
          end else begin
            stateNext_s = IDLE;
          end
        end else begin
          stateNext_s = STOP;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Output and datapath next values; TxD is computed from the next state so the flop leads the line.
  always_comb begin
    shiftNext_s   = shift_r;
    bitIdxNext_s  = bitIdx_r;
    baudCntNext_s = baudCnt_r;
    txdNext_s     = 1'b1;
    countNext_s   = count_r;
    busyNext_s    = 1'b0;

    if (pop_s) begin
      shiftNext_s = fifoMem_r[rdPtr_r];
    end else if ((state_r == DATA) && baudWrap_s) begin
      shiftNext_s = {1'b0, shift_r[7:1]};
    end else begin
      shiftNext_s = shift_r;
    end

    if (state_r == START) begin
      bitIdxNext_s = 3'd0;
    end else if ((state_r == DATA) && baudWrap_s) begin
      bitIdxNext_s = bitIdx_r + 3'd1;
    end else begin
      bitIdxNext_s = bitIdx_r;
    end

    if (pop_s || (stateNext_s == IDLE) || baudWrap_s) begin
      baudCntNext_s = CntW'(0);
    end else begin
      baudCntNext_s = baudCnt_r + CntW'(1);
    end

    case (stateNext_s)
      START:   txdNext_s = 1'b0;
      DATA:    txdNext_s = shiftNext_s[0];
      default: txdNext_s = 1'b1;
    endcase

    case ({push_s, pop_s})
      2'b10:   countNext_s = count_r + CountW'(1);
      2'b01:   countNext_s = count_r - CountW'(1);
      default: countNext_s = count_r;
    endcase

    busyNext_s = (stateNext_s != IDLE) || (countNext_s != CountW'(0));
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= 8'h00;
      bitIdx_r  <= 3'd0;
      baudCnt_r <= CntW'(0);
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      count_r   <= CountW'(0);
    end else begin
      shift_r   <= shiftNext_s;
      bitIdx_r  <= bitIdxNext_s;
      baudCnt_r <= baudCntNext_s;
      txd_r     <= txdNext_s;
      busy_r    <= busyNext_s;
      count_r   <= countNext_s;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_r <= PtrW'(0);
      rdPtr_r <= PtrW'(0);
    end else begin
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PtrW'(1);
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PtrW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifoMem_r[wrPtr_r] <= data;
    end
  end

endmodule

// File: tb/tb_uart_report_transmitter.sv
// Self-checking bench: a queue-based frame model checks the 10-bit/Divisor DUT every cycle,
// a line decoder recovers the sent bytes, and a second instance covers 100 MHz / 115200 loopback.
module tb_uart_report_transmitter;

  localparam int D  = 10;
  localparam int D2 = 868;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv, dv2;
  logic [7:0] dat, dat2;
  logic       ready, txd, busy;
  logic       ready2, txd2, busy2;
  logic [4:0] fifoCount, fifoCount2;

  always #5 clk = ~clk;

  uart_report_transmitter #(.ClkFrequency(1_000_000), .Baud(100_000), .FifoDepth(16)) dut (
    .clk(clk), .rst(rst), .dataValid(dv), .data(dat),
    .ready(ready), .TxD(txd), .busy(busy), .fifoCount(fifoCount)
  );

  uart_report_transmitter #(.ClkFrequency(100_000_000), .Baud(115200), .FifoDepth(16)) dutLb (
    .clk(clk), .rst(rst), .dataValid(dv2), .data(dat2),
    .ready(ready2), .TxD(txd2), .busy(busy2), .fifoCount(fifoCount2)
  );

  int checks = 0;
  int passes = 0;

  // model state
  int  q[$];
  int  curByte;
  longint popEdge;
  bit  inFlight;
  longint absEdge = 0;
  int  edgeNo = 0;

  // history for literal pins
  logic histTx[512];
  logic histBusy[512];
  logic histReady[512];
  int   histCnt[512];

  // line decoders
  bit         rxAct[2];
  int         rxPh[2];
  logic [7:0] rxSh[2];
  int         rxQ0[$];
  int         rxQ1[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else passes++;
  endtask

  task automatic modelStep();
    int  pre;
    bit  doPop, doPush;
    if (!rst) begin
      q.delete();
      inFlight = 1'b0;
      return;
    end
    pre    = q.size();
    doPop  = 1'b0;
    if (!inFlight && pre > 0) doPop = 1'b1;
    else if (inFlight && absEdge == popEdge + 10 * D) begin
      if (pre > 0) doPop = 1'b1;
      else inFlight = 1'b0;
    end
    doPush = (dv === 1'b1) && (pre != 16);
    if (doPop) begin
      curByte  = q.pop_front();
      popEdge  = absEdge;
      inFlight = 1'b1;
    end
    if (doPush) q.push_back(int'(dat));
  endtask

  function automatic logic expTxd();
    int j, slot;
    if (!inFlight) return 1'b1;
    j    = int'(absEdge - popEdge);
    slot = j / D;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return 1'((curByte >> (slot - 1)) & 1);
  endfunction

  task automatic decode(input int c, input logic line, input int div);
    int ph, half;
    if (!rst) begin
      rxAct[c] = 1'b0;
      return;
    end
    half = div / 2;
    if (!rxAct[c]) begin
      if (line == 1'b0) begin
        rxAct[c] = 1'b1;
        rxPh[c]  = 0;
      end
    end else begin
      rxPh[c]++;
      ph = rxPh[c];
      if (ph >= half + div && ph <= half + 8 * div && ((ph - half) % div) == 0)
        rxSh[c] = {line, rxSh[c][7:1]};
      if (ph == half + 9 * div) begin
        if (c == 0) rxQ0.push_back(line ? int'(rxSh[c]) : 32'h100);
        else        rxQ1.push_back(line ? int'(rxSh[c]) : 32'h100);
        rxAct[c] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    absEdge++;
    edgeNo++;
    modelStep();
    check("txd",       32'(txd),       32'(expTxd()));
    check("busy",      32'(busy),      32'(inFlight || q.size() > 0));
    check("fifoCount", 32'(fifoCount), 32'(q.size()));
    check("ready",     32'(ready),     32'(q.size() != 16));
    if (edgeNo < 512) begin
      histTx[edgeNo]    = txd;
      histBusy[edgeNo]  = busy;
      histReady[edgeNo] = ready;
      histCnt[edgeNo]   = int'(fifoCount);
    end
    decode(0, txd, D);
    decode(1, txd2, D2);
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && busy; i++) tick();
    check("idleTimeout", 32'(busy), 32'(0));
  endtask

  task automatic checkRx0(input string nm, input int n, input int first);
    check({nm, "_count"}, 32'(rxQ0.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check({nm, "_byte"}, (i < rxQ0.size()) ? 32'(rxQ0[i]) : 32'hFFFF, 32'(first + i));
    rxQ0.delete();
  endtask

  logic [7:0] lb [8];

  initial begin
    lb = '{8'h1B, 8'h5B, 8'h31, 8'h32, 8'h3B, 8'h34, 8'h30, 8'h52};
    rst = 1'b1; dv = 1'b0; dat = 8'h00; dv2 = 1'b0; dat2 = 8'h00;
    #2 rst = 1'b0;
    #1;
    check("rst_txd",   32'(txd),       32'(1));
    check("rst_ready", 32'(ready),     32'(1));
    check("rst_busy",  32'(busy),      32'(0));
    check("rst_count", 32'(fifoCount), 32'(0));
    repeat (3) tick();
    rst = 1'b1;

    // single byte 0x55 written at edge 5
    edgeNo = 0;
    repeat (4) tick();
    dv = 1'b1; dat = 8'h55;
    tick();
    dv = 1'b0;
    repeat (110) tick();
    check("single_cnt5",   32'(histCnt[5]),  32'(1));
    check("single_cnt6",   32'(histCnt[6]),  32'(0));
    check("single_start",  32'(histTx[6]),   32'(0));
    check("single_start2", 32'(histTx[15]),  32'(0));
    check("single_bit0",   32'(histTx[16]),  32'(1));
    check("single_bit1",   32'(histTx[26]),  32'(0));
    check("single_bit7",   32'(histTx[86]),  32'(0));
    check("single_stop",   32'(histTx[96]),  32'(1));
    check("single_busy105", 32'(histBusy[105]), 32'(1));
    check("single_busy106", 32'(histBusy[106]), 32'(0));
    checkRx0("single_rx", 1, 8'h55);

    // burst 0x41..0x43 on consecutive edges
    edgeNo = 0;
    dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dat = 8'(8'h41 + i);
      tick();
    end
    dv = 1'b0;
    waitIdle(400);
    check("burst_cnt1",   32'(histCnt[1]),   32'(1));
    check("burst_cnt2",   32'(histCnt[2]),   32'(1));
    check("burst_cnt3",   32'(histCnt[3]),   32'(2));
    check("burst_stop1",  32'(histTx[101]),  32'(1));
    check("burst_start2", 32'(histTx[102]),  32'(0));
    check("burst_cnt102", 32'(histCnt[102]), 32'(1));
    check("burst_start3", 32'(histTx[202]),  32'(0));
    check("burst_cnt202", 32'(histCnt[202]), 32'(0));
    check("burst_busy301", 32'(histBusy[301]), 32'(1));
    check("burst_busy302", 32'(histBusy[302]), 32'(0));
    checkRx0("burst_rx", 3, 8'h41);

    // overflow: 20 consecutive writes 0x00..0x13
    edgeNo = 0;
    dv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dat = 8'(i);
      tick();
    end
    dv = 1'b0;
    check("ovf_ready16", 32'(histReady[16]), 32'(1));
    check("ovf_cnt17",   32'(histCnt[17]),   32'(16));
    check("ovf_ready17", 32'(histReady[17]), 32'(0));
    check("ovf_cnt20",   32'(histCnt[20]),   32'(16));
    waitIdle(2000);
    checkRx0("ovf_rx", 17, 8'h00);

    // reset during data bit 3 of 0xA5 with two more bytes queued
    edgeNo = 0;
    dv = 1'b1;
    dat = 8'hA5; tick();
    dat = 8'h01; tick();
    dat = 8'h02; tick();
    dv = 1'b0;
    repeat (42) tick();
    #3;
    check("mid_bit3",   32'(txd),       32'(0));
    check("mid_count",  32'(fifoCount), 32'(2));
    rst = 1'b0;
    #1;
    check("arst_txd",   32'(txd),       32'(1));
    check("arst_count", 32'(fifoCount), 32'(0));
    check("arst_busy",  32'(busy),      32'(0));
    check("arst_ready", 32'(ready),     32'(1));
    repeat (2) tick();
    rst = 1'b1;
    dv = 1'b1; dat = 8'h3C;
    tick();
    dv = 1'b0;
    waitIdle(200);
    checkRx0("post_rst_rx", 1, 8'h3C);

    // loopback at 100 MHz / 115200 baud
    dv2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dat2 = lb[i];
      tick();
    end
    dv2 = 1'b0;
    for (int i = 0; i < 8 * 10 * D2 + 2000 && busy2; i++) tick();
    check("lb_idleTimeout", 32'(busy2), 32'(0));
    repeat (5) tick();
    check("lb_count", 32'(rxQ1.size()), 32'(8));
    for (int i = 0; i < 8; i++)
      check("lb_byte", (i < rxQ1.size()) ? 32'(rxQ1[i]) : 32'hFFFF, 32'(lb[i]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
